// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Requester-side handshake and regfile write-port bundle for
//               the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          in1_we;
  logic [SEL_WIDTH-1:0]          in1_sel;
  logic [DATA_WIDTH-1:0]         in1_data;
  logic                          in2_we;
  logic [SEL_WIDTH-1:0]          in2_sel;
  logic [DATA_WIDTH-1:0]         in2_data;

  // Producer / regfile side: drives requests, observes accepts and writes
  modport master (
    output req_valid, req_sel, req_data,
    input  req_ready, in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_sel, req_data,
    output req_ready, in1_we, in1_sel, in1_data, in2_we, in2_sel, in2_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter granting up to two
//               non-conflicting register writes per cycle onto the two
//               regfile write ports, outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   c_num_req  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] c_last_idx = PTR_W'(NUM_REQ-1);

  logic [SEL_WIDTH-1:0]  w_sel  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_data [NUM_REQ];

  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W:0]        w_scan_sum;
  logic [PTR_W-1:0]      w_scan_idx;

  logic                  w_a_found;
  logic [PTR_W-1:0]      w_a_idx;
  logic [SEL_WIDTH-1:0]  w_a_sel;
  logic [DATA_WIDTH-1:0] w_a_data;
  logic                  w_b_found;
  logic [PTR_W-1:0]      w_b_idx;
  logic [SEL_WIDTH-1:0]  w_b_sel;
  logic [DATA_WIDTH-1:0] w_b_data;

  logic [NUM_REQ-1:0]    w_ready;
  logic [PTR_W-1:0]      w_last_idx;
  logic [PTR_W-1:0]      w_ptr_next;

  logic                  r_in1_we;
  logic [SEL_WIDTH-1:0]  r_in1_sel;
  logic [DATA_WIDTH-1:0] r_in1_data;
  logic                  r_in2_we;
  logic [SEL_WIDTH-1:0]  r_in2_sel;
  logic [DATA_WIDTH-1:0] r_in2_data;

  // Split the packed request buses into per-requester fields
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_sel[gi]  = bus.req_sel[gi*SEL_WIDTH +: SEL_WIDTH];
    assign w_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from the pointer: first valid is A, next valid with a different sel is B
  always_comb begin
    w_a_found  = 1'b0;
    w_a_idx    = '0;
    w_a_sel    = '0;
    w_a_data   = '0;
    w_b_found  = 1'b0;
    w_b_idx    = '0;
    w_b_sel    = '0;
    w_b_data   = '0;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_scan_sum >= c_num_req) begin
        w_scan_sum = w_scan_sum - c_num_req;
      end
      w_scan_idx = w_scan_sum[PTR_W-1:0];
      // Fields of a non-valid requester are never looked at
      if (bus.req_valid[w_scan_idx]) begin
        if (!w_a_found) begin
          w_a_found = 1'b1;
          w_a_idx   = w_scan_idx;
          w_a_sel   = w_sel[w_scan_idx];
          w_a_data  = w_data[w_scan_idx];
        end else if (!w_b_found && (w_sel[w_scan_idx] != w_a_sel)) begin
          w_b_found = 1'b1;
          w_b_idx   = w_scan_idx;
          w_b_sel   = w_sel[w_scan_idx];
          w_b_data  = w_data[w_scan_idx];
        end
      end
    end
  end

  // Accept only the two grants, and nothing while reset is held
  always_comb begin
    w_ready = '0;
    if (!rst) begin
      if (w_a_found) w_ready[w_a_idx] = 1'b1;
      if (w_b_found) w_ready[w_b_idx] = 1'b1;
    end
  end

  assign bus.req_ready = w_ready;

  // Pointer moves just past the last grant in scan order
  always_comb begin
    w_last_idx = w_b_found ? w_b_idx : w_a_idx;
    w_ptr_next = (w_last_idx == c_last_idx) ? '0 : w_last_idx + 1'b1;
  end

  // Round-robin pointer, holds when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_a_found) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

  // Registered write ports; sel/data hold while the port is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in1_we   <= 1'b0;
      r_in1_sel  <= '0;
      r_in1_data <= '0;
      r_in2_we   <= 1'b0;
      r_in2_sel  <= '0;
      r_in2_data <= '0;
    end else begin
      r_in1_we <= w_a_found;
      r_in2_we <= w_b_found;
      if (w_a_found) begin
        r_in1_sel  <= w_a_sel;
        r_in1_data <= w_a_data;
      end
      if (w_b_found) begin
        r_in2_sel  <= w_b_sel;
        r_in2_data <= w_b_data;
      end
    end
  end

  assign bus.in1_we   = r_in1_we;
  assign bus.in1_sel  = r_in1_sel;
  assign bus.in1_data = r_in1_data;
  assign bus.in2_we   = r_in2_we;
  assign bus.in2_sel  = r_in2_sel;
  assign bus.in2_data = r_in2_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for the write-back arbiter: vector table
//               with an output scoreboard, a regfile model, and hand-written
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16), .SEL_WIDTH(4)) bus ();

  regfile_wb_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .SEL_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] sel;
    logic [63:0] data;
    logic [3:0]  ready;
    logic        we1;
    logic [3:0]  sel1;
    logic [15:0] d1;
    logic        we2;
    logic [3:0]  sel2;
    logic [15:0] d2;
  } vec_t;

  typedef struct {
    logic        we1;
    logic [3:0]  sel1;
    logic [15:0] d1;
    logic        we2;
    logic [3:0]  sel2;
    logic [15:0] d2;
  } exp_t;

  localparam int NV = 19;
  vec_t vecs [NV];
  exp_t sb [$];
  logic [15:0] rf [16];
  logic [15:0] rf_exp [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_in1_we"},   64'(bus.in1_we),   64'(e.we1));
      chk({tag, "_in1_sel"},  64'(bus.in1_sel),  64'(e.sel1));
      chk({tag, "_in1_data"}, 64'(bus.in1_data), 64'(e.d1));
      chk({tag, "_in2_we"},   64'(bus.in2_we),   64'(e.we2));
      chk({tag, "_in2_sel"},  64'(bus.in2_sel),  64'(e.sel2));
      chk({tag, "_in2_data"}, 64'(bus.in2_data), 64'(e.d2));
    end
  endtask

  // Regfile model: commits whatever the write ports carry at each edge
  always @(posedge clk) begin
    if (bus.in1_we) rf[bus.in1_sel] <= bus.in1_data;
    if (bus.in2_we) rf[bus.in2_sel] <= bus.in2_data;
  end

  // Dual writes must never target the same register
  always @(negedge clk) begin
    if (bus.in1_we && bus.in2_we) begin
      checks++;
      if (bus.in1_sel == bus.in2_sel) begin
        errors++;
        $display("FAIL dual_write_sel actual=%h required=not_%h", bus.in2_sel, bus.in1_sel);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int r = 0; r < 16; r++) begin
      rf[r] = 16'h0;
      rf_exp[r] = 16'h0;
    end

    //          valid    sel       data                    ready    we1 s1 d1        we2 s2 d2
    vecs[0]  = '{4'b1111, 16'h4321, 64'h4444_3333_2222_1111, 4'b0011, 1, 1, 16'h1111, 1, 2, 16'h2222};
    vecs[1]  = '{4'b1100, 16'h4321, 64'h4444_3333_2222_1111, 4'b1100, 1, 3, 16'h3333, 1, 4, 16'h4444};
    vecs[2]  = '{4'b0000, 16'h0000, 64'h0,                   4'b0000, 0, 3, 16'h3333, 0, 4, 16'h4444};
    vecs[3]  = '{4'b0001, 16'hxxx1, 64'hxxxx_xxxx_xxxx_DEAD, 4'b0001, 1, 1, 16'hDEAD, 0, 4, 16'h4444};
    vecs[4]  = '{4'b1000, 16'h7000, 64'h7777_0000_0000_0000, 4'b1000, 1, 7, 16'h7777, 0, 4, 16'h4444};
    vecs[5]  = '{4'b0111, 16'h0655, 64'h0000_CCCC_BBBB_AAAA, 4'b0101, 1, 5, 16'hAAAA, 1, 6, 16'hCCCC};
    vecs[6]  = '{4'b0010, 16'h0655, 64'h0000_CCCC_BBBB_AAAA, 4'b0010, 1, 5, 16'hBBBB, 0, 6, 16'hCCCC};
    vecs[7]  = '{4'b1011, 16'hA098, 64'h0A0A_0000_0909_0808, 4'b1001, 1, 10, 16'h0A0A, 1, 8, 16'h0808};
    vecs[8]  = '{4'b0010, 16'hA098, 64'h0A0A_0000_0909_0808, 4'b0010, 1, 9, 16'h0909, 0, 8, 16'h0808};
    vecs[9]  = '{4'b1111, 16'hBBBB, 64'h0004_0003_0002_0001, 4'b0100, 1, 11, 16'h0003, 0, 8, 16'h0808};
    vecs[10] = '{4'b1011, 16'hBBBB, 64'h0004_0003_0002_0001, 4'b1000, 1, 11, 16'h0004, 0, 8, 16'h0808};
    vecs[11] = '{4'b0011, 16'hBBBB, 64'h0004_0003_0002_0001, 4'b0001, 1, 11, 16'h0001, 0, 8, 16'h0808};
    vecs[12] = '{4'b0010, 16'hBBBB, 64'h0004_0003_0002_0001, 4'b0010, 1, 11, 16'h0002, 0, 8, 16'h0808};
    for (int i = 13; i < 18; i++)
      vecs[i] = '{4'b0000, 16'h0000, 64'h0,                  4'b0000, 0, 11, 16'h0002, 0, 8, 16'h0808};
    // Pointer must still be 2 after the idle stretch: scan 2,3,0 -> A=3, B=0
    vecs[18] = '{4'b1001, 16'hD00C, 64'h1313_0000_0000_1212, 4'b1001, 1, 13, 16'h1313, 1, 12, 16'h1212};

    // Reset with every requester valid
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_sel   = 16'h4321;
    bus.req_data  = 64'h4444_3333_2222_1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    64'(bus.req_ready), 64'h0);
    chk("rst_in1_we",   64'(bus.in1_we),    64'h0);
    chk("rst_in2_we",   64'(bus.in2_we),    64'h0);
    chk("rst_in1_sel",  64'(bus.in1_sel),   64'h0);
    chk("rst_in1_data", 64'(bus.in1_data),  64'h0);
    chk("rst_in2_sel",  64'(bus.in2_sel),   64'h0);
    chk("rst_in2_data", 64'(bus.in2_data),  64'h0);

    // Vector table: ready checked in the drive cycle, ports one cycle later
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.req_valid = vecs[i].valid;
      bus.req_sel   = vecs[i].sel;
      bus.req_data  = vecs[i].data;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), 64'(bus.req_ready), 64'(vecs[i].ready));
      if (i > 0) pop_cmp($sformatf("row%0d", i - 1));
      sb.push_back('{vecs[i].we1, vecs[i].sel1, vecs[i].d1, vecs[i].we2, vecs[i].sel2, vecs[i].d2});
    end
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    pop_cmp($sformatf("row%0d", NV - 1));

    // Mid-operation reset: pointer is 1, so requester 1 is granted alone
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0010;
    bus.req_sel   = 16'h00E0;
    bus.req_data  = 64'h0000_0000_EEEE_0000;
    @(negedge clk);
    chk("mid_ready", 64'(bus.req_ready), 64'h2);
    @(posedge clk);
    #1;
    chk("mid_in1_we",   64'(bus.in1_we),   64'h1);
    chk("mid_in1_sel",  64'(bus.in1_sel),  64'hE);
    chk("mid_in1_data", 64'(bus.in1_data), 64'hEEEE);
    bus.req_valid = 4'b0110;
    bus.req_sel   = 16'h0FE0;
    bus.req_data  = 64'h0000_FFFF_EEEE_0000;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in1_we",   64'(bus.in1_we),    64'h0);
    chk("midrst_in2_we",   64'(bus.in2_we),    64'h0);
    chk("midrst_ready",    64'(bus.req_ready), 64'h0);
    chk("midrst_in1_data", 64'(bus.in1_data),  64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rsthold_in1_we", 64'(bus.in1_we), 64'h0);
    chk("rsthold_in2_we", 64'(bus.in2_we), 64'h0);
    chk("lost_write_r14", 64'(rf[14]),     64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Pointer back to 0: scan 0,1,2 -> A=1 on port 1, B=2 on port 2
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.req_ready), 64'h6);
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0000;
    chk("post_rst_in1_we",   64'(bus.in1_we),   64'h1);
    chk("post_rst_in1_sel",  64'(bus.in1_sel),  64'hE);
    chk("post_rst_in1_data", 64'(bus.in1_data), 64'hEEEE);
    chk("post_rst_in2_we",   64'(bus.in2_we),   64'h1);
    chk("post_rst_in2_sel",  64'(bus.in2_sel),  64'hF);
    chk("post_rst_in2_data", 64'(bus.in2_data), 64'hFFFF);
    @(posedge clk);
    #1;

    // Final regfile contents
    rf_exp[1]  = 16'hDEAD; rf_exp[2]  = 16'h2222; rf_exp[3]  = 16'h3333;
    rf_exp[4]  = 16'h4444; rf_exp[5]  = 16'hBBBB; rf_exp[6]  = 16'hCCCC;
    rf_exp[7]  = 16'h7777; rf_exp[8]  = 16'h0808; rf_exp[9]  = 16'h0909;
    rf_exp[10] = 16'h0A0A; rf_exp[11] = 16'h0002; rf_exp[12] = 16'h1212;
    rf_exp[13] = 16'h1313; rf_exp[14] = 16'hEEEE; rf_exp[15] = 16'hFFFF;
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("rf_r%0d", r), 64'(rf[r]), 64'(rf_exp[r]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back arbiter for the 16x16 two-write-port register file.
- Shares the regfile's two write ports (in1, in2) among NUM_REQ producers, e.g. ALU, load unit and multiplier.
- Grants up to two writes per cycle in round-robin order, never issues two same-cycle writes to the same register, and drives the regfile write ports from registers.
- Sits between the execution units and the regfile write side.

Parameters:
NUM_REQ, 4, number of requesters (supported range 2..8)
DATA_WIDTH, 16, register data width
SEL_WIDTH, 4, register select width (2**SEL_WIDTH registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_sel  input  NUM_REQ*SEL_WIDTH  packed target register selects, requester i at [i*SEL_WIDTH +: SEL_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept; combinational
in1_we  output  1  regfile write port 1 enable (registered)
in1_sel  output  SEL_WIDTH  regfile write port 1 select (registered)
in1_data  output  DATA_WIDTH  regfile write port 1 data (registered)
in2_we  output  1  regfile write port 2 enable (registered)
in2_sel  output  SEL_WIDTH  regfile write port 2 select (registered)
in2_data  output  DATA_WIDTH  regfile write port 2 data (registered)

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high; one clock domain.
- Reset values:
  - in1_we, in2_we = 0.
  - in1_sel, in2_sel, in1_data, in2_data = 0.
  - Round-robin pointer rr_ptr = 0.
  - req_ready = 0 while rst is high.
- Handshake:
  - Transfer occurs at a rising edge when req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid/sel/data stable until accepted.
  - req_ready[i] never asserts without req_valid[i].
- Arbitration (combinational, each cycle):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - First valid requester found = grant A.
  - Continue the scan; the next valid requester whose sel != sel of A = grant B.
  - Valid requesters whose sel equals A's sel are skipped this cycle; they are not granted.
  - At most 2 grants per cycle; req_ready asserts only for A and B.
- Port mapping: grant A -> port 1, grant B -> port 2. If only A exists, in2_we = 0 next cycle.
- Registered outputs: at the edge ending the grant cycle:
  - in1_we <= (A exists); in1_sel/in1_data <= A's sel/data.
  - Likewise port 2 for B.
  - When a port's we is 0, its sel/data hold their previous values.
- Latency:
  - Request accepted at edge N; write port driven during cycle N+1; regfile commits at edge N+1.
  - Value is readable on a regfile read port after edge N+1.
- Pointer update:
  - rr_ptr <= (index of the last grant in scan order) + 1 mod NUM_REQ, i.e. B if present, else A.
  - No grants: rr_ptr holds.
- Fairness: any continuously-valid requester is granted within NUM_REQ cycles, including one blocked by a same-sel conflict.
- Invariant: in1_we & in2_we implies in1_sel != in2_sel. The regfile never sees a same-register dual write from this block.
- Reset mid-operation:
  - in1_we/in2_we drop immediately, not at the next edge; the in-flight write is lost.
  - Requests presented during reset are not accepted.
  - First grant after release scans from index 0.
- X on req_sel/req_data of a non-valid requester has no effect on outputs.

Test Plan:
- Reset: rst=1 with req_valid=4'b1111 -> req_ready=0, in1_we=in2_we=0, sel/data=0; after release, first grants are requesters 0 and 1.
- Single write: req0 sel=1 data=16'hDEAD -> req_ready=4'b0001 same cycle; next cycle in1_we=1, in1_sel=1, in1_data=DEAD, in2_we=0; regfile r1 reads DEAD after that edge.
- Round-robin, 4 requesters held valid, sel 1..4, data 1111/2222/3333/4444, rr_ptr=0:
  - Cycle A grants 0 (port1) and 1 (port2); rr_ptr=2.
  - Cycle B grants 2 and 3; rr_ptr=0.
  - Regfile r1..r4 = 1111..4444.
- Conflict: req0 sel=5 data=AAAA, req1 sel=5 data=BBBB, req2 sel=6 data=CCCC, rr_ptr=0:
  - Grants 0 (port1) and 2 (port2); req1 waits; rr_ptr=3.
  - Next cycle req1 is granted on port1, in2_we=0.
  - Final r5=BBBB, r6=CCCC.
- Mid-operation reset: rst pulsed between edges while in1_we=1 -> in1_we falls before the next clk edge; regfile target unchanged; after release rr_ptr=0.
- Idle: req_valid=0 for 5 cycles -> in1_we=in2_we=0 every cycle, rr_ptr unchanged, sel/data outputs hold.
